// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the step/run clock-enable controller.
// Debouncer state encoding and synchronizer depth.
package step_ctrl_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // Debouncer states, 2-bit encoding.
    typedef logic [1:0] db_state_t;

    localparam db_state_t DB_IDLE      = 2'd0;
    localparam db_state_t DB_CHK_PRESS = 2'd1;
    localparam db_state_t DB_PRESSED   = 2'd2;
    localparam db_state_t DB_CHK_REL   = 2'd3;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Synchronizer plus four-state debouncer for one raw input.
// level is registered; rise strobes in the cycle before level goes high.
module debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    // The entry sample from a stable state counts as the first of DB_CYCLES.
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   din_s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        din_s   = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            DB_IDLE: begin
                if (din_s) state_d = DB_CHK_PRESS;
            end
            DB_CHK_PRESS: begin
                if (!din_s)             state_d = DB_IDLE;
                else if (cnt_q == LAST) state_d = DB_PRESSED;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            DB_PRESSED: begin
                if (!din_s) state_d = DB_CHK_REL;
            end
            DB_CHK_REL: begin
                if (din_s)              state_d = DB_PRESSED;
                else if (cnt_q == LAST) state_d = DB_IDLE;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = DB_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        level_d = (state_d == DB_PRESSED) || (state_d == DB_CHK_REL);
        rise    = (state_q == DB_CHK_PRESS) && (state_d == DB_PRESSED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/step_ctrl.sv
// Clock-enable source: one en pulse per debounced press in step mode,
// one en pulse every div+1 clocks in run mode.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_step,
    input  logic          sw_run,
    input  logic [DW-1:0] div,
    output logic          en,
    output logic          btn_db,
    output logic          run
);

    logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
    logic [DW-1:0]          pcnt_q, pcnt_d;
    logic                   en_q, en_d;
    logic                   run_q, run_next;
    logic                   step_rise;

    debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_db (
        .clk  (clk),
        .reset(reset),
        .din  (btn_step),
        .level(btn_db),
        .rise (step_rise)
    );

    always_comb begin
        run_sync_d = {run_sync_q[SYNC_STAGES-2:0], sw_run};
        run_q      = run_sync_q[SYNC_STAGES-1];
        run_next   = run_sync_q[SYNC_STAGES-2];
        pcnt_d     = '0;
        en_d       = 1'b0;

        // A mode change holds en low and restarts the prescaler.
        if (run_next == run_q) begin
            if (run_q) begin
                if (pcnt_q >= div) en_d   = 1'b1;
                else               pcnt_d = pcnt_q + DW'(1);
            end else begin
                en_d = step_rise;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_sync_q <= '0;
            pcnt_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            run_sync_q <= run_sync_d;
            pcnt_q     <= pcnt_d;
            en_q       <= en_d;
        end
    end

    assign en  = en_q;
    assign run = run_q;

endmodule
